cla_slice_sequencer: RTL and testbench

Multi-cycle wide adder controller that time-shares one combinational CLA_16bit instance across SLICES 16-bit slices of a WIDTH-bit operand pair.
- Accepts operands with a valid/ready handshake.
- Feeds one slice per clock to the CLA, least significant slice first.
- Chains the carry through a register and assembles the sum.
- Presents sum, carry-out, signed overflow and group-propagate status with a valid/ready handshake.
- Sits between operand producers and consumers wherever wide adds are needed but only one 16-bit CLA is budgeted.

---
 rtl/cla_slice_sequencer_pkg.sv | 19 +
 rtl/cla_slice_sequencer_if.sv | 31 +++
 rtl/cla_slice_sequencer_cla16.sv | 55 +++++
 rtl/cla_slice_sequencer.sv | 120 ++++++++++++
 tb/tb_cla_slice_sequencer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/cla_slice_sequencer_pkg.sv
// Shared definitions for the sliced wide-adder sequencer.
//   SLICE_W      : width of the shared CLA datapath
//   ST_*         : FSM state encodings
//   seq_flags_t  : result status bits registered alongside the sum
package cla_slice_sequencer_pkg;

   localparam int SLICE_W = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic all_prop;
   } seq_flags_t;

endpackage

// File: rtl/cla_slice_sequencer_if.sv
// Operand/result handshake bundle for cla_slice_sequencer.
//   master : operand producer / result consumer (drives in_valid, a, b, cin, out_ready)
//   slave  : the sequencer (drives in_ready, out_valid, sum, cout, ovf, all_prop)
interface cla_slice_sequencer_if #(
   parameter int SLICES = 4
);
   localparam int WIDTH = 16 * SLICES;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             all_prop;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, all_prop
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf, all_prop
   );

endinterface

// File: rtl/cla_slice_sequencer_cla16.sv
// 16-bit two-level carry-lookahead adder (4 groups of 4 bits).
//   A, B, c0 : operands and carry in
//   sum      : A+B+c0 low 16 bits
//   Cout     : carry out of bit 15
//   PG, GG   : group propagate / generate over all 16 bits
module CLA_16bit (
   output logic [15:0] sum,
   output logic        Cout,
   output logic        PG,
   output logic        GG,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        c0
);

   logic [15:0] p, g, c;
   logic [3:0]  gp, gg;
   logic [4:0]  gc;

   assign p = A ^ B;
   assign g = A & B;

   always_comb begin
      gp = '0;
      gg = '0;
      gc = '0;
      c  = '0;
      for (int j = 0; j < 4; j++) begin
         gp[j] = &p[4*j +: 4];
         gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      end
      // Second-level lookahead: group carries straight from c0.
      gc[0] = c0;
      gc[1] = gg[0] | (gp[0] & c0);
      gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
      gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c0);
      gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & c0);
      // First-level lookahead inside each group from its group carry.
      for (int j = 0; j < 4; j++) begin
         c[4*j]   = gc[j];
         c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
         c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
         c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      end
   end

   assign sum  = p ^ c;
   assign Cout = gc[4];
   assign PG   = &gp;
   assign GG   = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);

endmodule

// File: rtl/cla_slice_sequencer.sv
// Wide adder that time-shares one CLA_16bit over SLICES 16-bit slices,
// least significant slice first, chaining the carry through a register.
//   clk, rst_n : clock, async active-low reset
//   bus        : operand in / result out handshakes (slave side)
//   busy       : high while an operation is running or its result is held
module cla_slice_sequencer
   import cla_slice_sequencer_pkg::*;
#(
   parameter int SLICES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cla_slice_sequencer_if.slave bus,
   output logic                 busy
);

   localparam int WIDTH = SLICE_W * SLICES;
   localparam int K_W   = $clog2(SLICES);
   localparam logic [K_W-1:0] K_LAST = K_W'(SLICES - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [K_W-1:0]   k_q, k_d;
   logic             carry_q, carry_d, prop_q, prop_d;
   logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
   seq_flags_t       flags_q, flags_d;

   logic [SLICE_W-1:0] cla_sum;
   logic               cla_cout, cla_pg, cla_gg_unused;

   CLA_16bit u_cla (
      .sum  (cla_sum),
      .Cout (cla_cout),
      .PG   (cla_pg),
      .GG   (cla_gg_unused),
      .A    (a_q[k_q*SLICE_W +: SLICE_W]),
      .B    (b_q[k_q*SLICE_W +: SLICE_W]),
      .c0   (carry_q)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      k_d     = k_q;
      carry_d = carry_q;
      prop_d  = prop_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      flags_d = flags_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               a_msb_d = bus.a[WIDTH-1];
               b_msb_d = bus.b[WIDTH-1];
               prop_d  = 1'b1;
               k_d     = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_d[k_q*SLICE_W +: SLICE_W] = cla_sum;
            carry_d = cla_cout;
            prop_d  = prop_q & cla_pg;
            if (k_q == K_LAST) begin
               flags_d.cout     = cla_cout;
               flags_d.all_prop = prop_q & cla_pg;
               // Signed overflow: like-signed operands, result sign differs.
               flags_d.ovf      = (a_msb_q == b_msb_q) && (cla_sum[SLICE_W-1] != a_msb_q);
               state_d          = ST_DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         prop_q  <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         prop_q  <= prop_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         flags_q <= flags_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = flags_q.cout;
   assign bus.ovf       = flags_q.ovf;
   assign bus.all_prop  = flags_q.all_prop;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cla_slice_sequencer.sv
module tb_cla_slice_sequencer;

   localparam int SLICES = 4;
   localparam int WIDTH  = 16 * SLICES;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      logic             all_prop;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   int   n_pass = 0;
   int   n_total = 0;
   int   n_fail = 0;
   exp_t sb[$];

   cla_slice_sequencer_if #(.SLICES(SLICES)) bus ();

   cla_slice_sequencer #(.SLICES(SLICES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: plain wide addition, independent of slicing.
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
      exp_t e;
      logic [WIDTH:0] full;
      full       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      e.sum      = full[WIDTH-1:0];
      e.cout     = full[WIDTH];
      e.ovf      = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
      e.all_prop = &(a ^ b);
      return e;
   endfunction

   // Drive one operand pair at a negedge, wait for its accepting edge.
   task automatic accept(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_in_ready"}, WIDTH'(bus.in_ready), WIDTH'(1));
      bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
      sb.push_back(model(a, b, cin));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = '1; bus.b = '1; bus.cin = 1'b1;   // operands free to change
   endtask

   // Count cycles to out_valid, then compare against the scoreboard head.
   task automatic collect(input string tag);
      exp_t e;
      for (int i = 1; i <= SLICES; i++) begin
         if (i > 1) @(posedge clk);
         if (i > 1) #1;
         else begin @(posedge clk); #1; end
         chk({tag, "_latency"}, WIDTH'(bus.out_valid), WIDTH'(i == SLICES));
      end
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, WIDTH'(1), WIDTH'(0));
      end else begin
         e = sb.pop_front();
         chk({tag, "_sum"},      bus.sum,             e.sum);
         chk({tag, "_cout"},     WIDTH'(bus.cout),     WIDTH'(e.cout));
         chk({tag, "_ovf"},      WIDTH'(bus.ovf),      WIDTH'(e.ovf));
         chk({tag, "_all_prop"}, WIDTH'(bus.all_prop), WIDTH'(e.all_prop));
         chk({tag, "_busy"},     WIDTH'(busy),         WIDTH'(1));
      end
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, "_ov_clr"}, WIDTH'(bus.out_valid), WIDTH'(0));
      chk({tag, "_rdy_set"}, WIDTH'(bus.in_ready), WIDTH'(1));
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
      accept(tag, a, b, cin);
      collect(tag);
      release_out(tag);
   endtask

   initial begin
      exp_t held;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sum",  bus.sum, '0);
      chk("rst_ov",   WIDTH'(bus.out_valid), WIDTH'(0));
      chk("rst_busy", WIDTH'(busy), WIDTH'(0));
      chk("rst_flags", WIDTH'({bus.cout, bus.ovf, bus.all_prop}), WIDTH'(0));
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));

      run_op("basic",  64'h0000_0000_0000_02EB, 64'h0000_0000_0000_5555, 1'b0);
      run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
      run_op("prop",   64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
      run_op("ovf",    64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
      run_op("rand",   {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));

      // Back-pressure: result held for 5 cycles while a new request is offered.
      held = model(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b1);
      accept("bp", 64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b1);
      collect("bp");
      bus.in_valid = 1'b1; bus.a = 64'd5; bus.b = 64'd6; bus.cin = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_ov",   WIDTH'(bus.out_valid), WIDTH'(1));
         chk("bp_hold_sum",  bus.sum, held.sum);
         chk("bp_hold_cout", WIDTH'(bus.cout), WIDTH'(held.cout));
         chk("bp_hold_rdy",  WIDTH'(bus.in_ready), WIDTH'(0));
      end
      bus.in_valid = 1'b0;
      release_out("bp");
      @(posedge clk);
      #1;
      chk("bp_ignored", WIDTH'(busy), WIDTH'(0));

      // Reset two cycles into RUN discards the operation.
      accept("rst_mid", 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("rstmid_sum",  bus.sum, '0);
      chk("rstmid_ov",   WIDTH'(bus.out_valid), WIDTH'(0));
      chk("rstmid_busy", WIDTH'(busy), WIDTH'(0));
      chk("rstmid_flags", WIDTH'({bus.cout, bus.ovf, bus.all_prop}), WIDTH'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_rst", 64'd1, 64'd2, 1'b0);
      chk("after_rst_sb", WIDTH'(sb.size()), WIDTH'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
